// File: rtl/ipod_pkg.sv
// Shared constants and the sequencer state type for the audio flash path.
package ipod_pkg;

  localparam int FLASH_ADDR_W = 23;
  localparam logic [FLASH_ADDR_W-1:0] AUDIO_LAST_ADDR = 23'h7FFFF;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_VALID,
    DONE
  } seq_state_t;

endpackage

// File: rtl/wrap_addr_counter.sv
// Up/down word-address counter that wraps between 0 and LAST, with a
// synchronous load that takes priority over stepping.
module wrap_addr_counter #(
  parameter int W = 23,
  parameter logic [W-1:0] LAST = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  input  logic         down,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (step) begin
      if (down) count <= (count == '0) ? LAST : count - ONE;
      else      count <= (count == LAST) ? '0 : count + ONE;
    end
  end

endmodule

// File: rtl/flash_read_sequencer.sv
// Fetches one 32-bit flash word per two sample requests, stepping the word
// address forward or backward with wrap, and applies deferred restarts.
module flash_read_sequencer
  import ipod_pkg::*;
#(
  parameter int ADDR_W = FLASH_ADDR_W,
  parameter logic [ADDR_W-1:0] LAST_ADDR = AUDIO_LAST_ADDR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read_start,
  input  logic              back_mode,
  input  logic              restart,
  output logic              flash_mem_read,
  input  logic              flash_mem_waitrequest,
  output logic [ADDR_W-1:0] flash_mem_address,
  output logic [3:0]        flash_mem_byteenable,
  input  logic [31:0]       flash_mem_readdata,
  input  logic              flash_mem_readdatavalid,
  output logic [31:0]       data_out,
  output logic              read_finish,
  output logic              is_first
);

  // Handshakes: read_start and read_finish are single-cycle pulses. The
  // Avalon read holds flash_mem_read and the address until a cycle with
  // waitrequest low (accepted); data is taken only when readdatavalid is high.

  seq_state_t        state;
  logic              phase;
  logic              restart_pending;
  logic [31:0]       word;
  logic              cnt_step;
  logic              cnt_load;
  logic [ADDR_W-1:0] cnt_load_val;

  // Restart beats the address step when both land in DONE.
  assign cnt_load     = restart_pending && (state == IDLE || state == DONE);
  assign cnt_step     = (state == DONE) && phase && !restart_pending;
  assign cnt_load_val = back_mode ? LAST_ADDR : '0;

  assign flash_mem_byteenable = 4'hF;
  assign data_out             = word;

  wrap_addr_counter #(
    .W    (ADDR_W),
    .LAST (LAST_ADDR)
  ) u_addr (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (cnt_step),
    .down     (back_mode),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .count    (flash_mem_address)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      phase           <= 1'b0;
      restart_pending <= 1'b0;
      word            <= '0;
      flash_mem_read  <= 1'b0;
      read_finish     <= 1'b0;
      is_first        <= 1'b0;
    end else begin
      read_finish     <= 1'b0;
      restart_pending <= restart | (restart_pending & ~cnt_load);
      if (cnt_load)           phase <= 1'b0;
      else if (state == DONE) phase <= ~phase;

      case (state)
        IDLE: begin
          // A restart being applied this cycle forces a fresh fetch.
          if (read_start) begin
            if (phase && !restart_pending) begin
              state       <= DONE;
              read_finish <= 1'b1;
              is_first    <= 1'b0;
            end else begin
              state          <= REQ;
              flash_mem_read <= 1'b1;
            end
          end
        end
        REQ: begin
          if (!flash_mem_waitrequest) begin
            flash_mem_read <= 1'b0;
            state          <= WAIT_VALID;
          end
        end
        WAIT_VALID: begin
          if (flash_mem_readdatavalid) begin
            word        <= flash_mem_readdata;
            state       <= DONE;
            read_finish <= 1'b1;
            is_first    <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
